button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   Conditions one raw push-button for the 7-segment counter top: 2-FF synchronizer,
//   counter-based debounce FSM, edge pulses, toggle latch, long-press detect.
//   One instance drives the counter's REVERSE input (TOGGLE); a second drives its
//   RESET input (RISE). Sits directly upstream of the Segment7 top, on the board clock.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000   consecutive stable cycles required to accept a level change (>=2)
//   HOLD_CYCLES      50000000 cycles of accepted-high before LONG fires (>DEBOUNCE_CYCLES)
//   BTN_ACTIVE_LOW   0        1: BTN_IN is inverted at input (pressed = 0)
// PORTS
//   CLK      in   1  board clock; all state on rising edge
//   RESET    in   1  synchronous, active-high reset
//   BTN_IN   in   1  raw asynchronous button pin
//   LEVEL    out  1  debounced pressed level
//   RISE     out  1  1-cycle pulse on accepted press
//   FALL     out  1  1-cycle pulse on accepted release
//   TOGGLE   out  1  flips on every RISE; feeds counter REVERSE
//   LONG     out  1  1-cycle pulse once per press after HOLD_CYCLES held
// BEHAVIOUR
//   - Reset (sync, active-high): sync regs=0, state=ST_LO, counters=0, all outputs 0.
//     RESET mid-debounce or mid-hold abandons that activity; no pulse is emitted.
//   - Input: b = BTN_IN ^ BTN_ACTIVE_LOW, through 2 flops -> s. s lags BTN_IN by 2 cycles.
//   - FSM, 4 states, cnt width $clog2(DEBOUNCE_CYCLES):
//     ST_LO:   LEVEL=0; s=1 -> ST_WHI, cnt<=0.
//     ST_WHI:  s=0 -> ST_LO (glitch rejected, no pulse); else cnt++;
//              cnt==DEBOUNCE_CYCLES-1 -> ST_HI, RISE pulse, TOGGLE<=~TOGGLE.
//     ST_HI:   LEVEL=1; s=0 -> ST_WLO, cnt<=0.
//     ST_WLO:  s=1 -> ST_HI (no pulse, hold count kept); else cnt++;
//              cnt==DEBOUNCE_CYCLES-1 -> ST_LO, FALL pulse.
//   - LEVEL=1 in ST_HI and ST_WLO; 0 in ST_LO and ST_WHI.
//   - All outputs registered. Clean press: RISE high exactly DEBOUNCE_CYCLES+2 cycles
//     after first edge sampling BTN_IN pressed. FALL latency is the same.
//   - Hold counter, width $clog2(HOLD_CYCLES+1):
//     - cleared on entry to ST_HI from ST_WHI; increments in ST_HI and ST_WLO.
//     - saturates at HOLD_CYCLES.
//     - LONG pulses in the single cycle it reaches HOLD_CYCLES-1; never again that press.
//     - cleared on entry to ST_LO.
//   - RISE, FALL and LONG never high in the same cycle. RISE and FALL are strictly alternating.
//   - TOGGLE changes only in the cycle RISE is asserted (same edge). It is unaffected by
//     FALL or LONG and holds its value across RESET deassertion at 0.
//   - Counter compare uses == on full-width unsigned values; no wrap (bounded by FSM).
// STRUCTURE
//   - Shared package seg7_pkg: state encodings ST_LO/ST_WHI/ST_HI/ST_WLO (2-bit localparams),
//     plus a DEBOUNCE_20MS cycle-count constant for the board clock.
//   - One sub-module: sync_2ff (CLK, RESET, D, Q), reusable for other async pins.
//   - Remainder inline: FSM, debounce counter, hold counter, output registers.
// TESTING (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16)
//   1 RESET held 3 cycles, BTN_IN=1 during reset -> all outputs 0. After release,
//     first RISE at cycle 6.
//   2 Clean press at cycle 10, held -> RISE=1 only at cycle 16; LEVEL=1 from cycle 16;
//     TOGGLE 0->1 at cycle 16.
//   3 Bounce: BTN_IN 1,0,1,1,0 then steady 1 -> no RISE until 4 stable cycles +2;
//     exactly one RISE.
//   4 Hold 30 cycles after RISE -> one LONG pulse 15 cycles after RISE; no second LONG.
//     Release -> FALL 6 cycles later.
//   5 Two separate clean presses -> TOGGLE 0->1->0. LONG absent for presses shorter than 16.
//   6 RESET asserted 2 cycles into ST_WHI, and again mid-hold -> no RISE/LONG; state ST_LO;
//     TOGGLE=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment counter board.
// Debounce FSM state encodings and board-clock timing constants.
package seg7_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_LO  = 2'd0;
   localparam state_t ST_WHI = 2'd1;
   localparam state_t ST_HI  = 2'd2;
   localparam state_t ST_WLO = 2'd3;

   // 25 MHz board clock: 20 ms is 500k cycles
   localparam int unsigned BOARD_CLK_HZ  = 25_000_000;
   localparam int unsigned DEBOUNCE_20MS = BOARD_CLK_HZ / 50;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous input pin.
// Synchronous active-high reset clears both stages.
module sync_2ff (
   input  logic CLK,
   input  logic RESET,
   input  logic D,
   output logic Q
);

   logic meta;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         meta <= 1'b0;
         Q    <= 1'b0;
      end else begin
         meta <= D;
         Q    <= meta;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizer, debounce FSM, edge pulses,
// toggle latch and long-press detect. All outputs registered.
module button_conditioner
   import seg7_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned HOLD_CYCLES     = 50000000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
   input  logic CLK,
   input  logic RESET,
   input  logic BTN_IN,
   output logic LEVEL,
   output logic RISE,
   output logic FALL,
   output logic TOGGLE,
   output logic LONG
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 2);

   logic          b;
   logic          s;
   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic [HW-1:0] hold;
   logic [HW-1:0] hold_nx;
   logic          rise_nx;
   logic          fall_nx;
   logic          long_nx;
   logic          in_hi;

   assign b = BTN_IN ^ BTN_ACTIVE_LOW;

   sync_2ff u_sync (
      .CLK   (CLK),
      .RESET (RESET),
      .D     (b),
      .Q     (s)
   );

   assign in_hi = (state == ST_HI) || (state == ST_WLO);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      hold_nx  = hold;
      rise_nx  = 1'b0;
      fall_nx  = 1'b0;
      long_nx  = 1'b0;
      case (state)
         ST_LO: begin
            if (s) begin
               state_nx = ST_WHI;
               cnt_nx   = '0;
            end
         end
         ST_WHI: begin
            if (!s) begin
               state_nx = ST_LO;
            end else if (cnt == CNT_LAST) begin
               state_nx = ST_HI;
               rise_nx  = 1'b1;
               hold_nx  = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         ST_HI: begin
            if (!s) begin
               state_nx = ST_WLO;
               cnt_nx   = '0;
            end
         end
         ST_WLO: begin
            if (s) begin
               state_nx = ST_HI;
            end else if (cnt == CNT_LAST) begin
               state_nx = ST_LO;
               fall_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = ST_LO;
      endcase
      // Hold time accumulates while pressed; a release drops it and
      // suppresses a LONG that would otherwise coincide with FALL.
      if (in_hi && hold != HOLD_MAX) hold_nx = hold + 1'b1;
      if (state_nx == ST_LO) hold_nx = '0;
      long_nx = in_hi && (state_nx != ST_LO) && (hold == HOLD_PRE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state  <= ST_LO;
         cnt    <= '0;
         hold   <= '0;
         LEVEL  <= 1'b0;
         RISE   <= 1'b0;
         FALL   <= 1'b0;
         TOGGLE <= 1'b0;
         LONG   <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         hold   <= hold_nx;
         LEVEL  <= (state_nx == ST_HI) || (state_nx == ST_WLO);
         RISE   <= rise_nx;
         FALL   <= fall_nx;
         TOGGLE <= TOGGLE ^ rise_nx;
         LONG   <= long_nx;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short debounce/hold times:
// directed segment table, bounce sequence, and random presses vs a run-length model.
module tb_button_conditioner;

   localparam int D = 4;
   localparam int H = 16;

   logic clk = 1'b0;
   logic reset;
   logic btn_in;
   logic level;
   logic rise;
   logic fall;
   logic toggle;
   logic long_p;

   int checks   = 0;
   int failures = 0;

   // model: 2-deep pin history, accepted level, run of disagreeing samples
   bit m_h1, m_h2;
   bit m_lvl, m_tog;
   bit m_rise, m_fall, m_long;
   int m_run, m_age;

   // per-segment observation
   int seg_idx, seg_r, seg_f, seg_l, first_p, first_l;

   typedef struct {
      bit rst;
      bit btn;
      int n;
      bit lvl;
      bit tog;
      int rises;
      int falls;
      int longs;
      int t_first;
      int t_long;
   } seg_t;

   seg_t segs [11];

   button_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .HOLD_CYCLES     (H),
      .BTN_ACTIVE_LOW  (1'b0)
   ) dut (
      .CLK    (clk),
      .RESET  (reset),
      .BTN_IN (btn_in),
      .LEVEL  (level),
      .RISE   (rise),
      .FALL   (fall),
      .TOGGLE (toggle),
      .LONG   (long_p)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit b);
      bit s;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_long = 1'b0;
      if (r) begin
         m_h1  = 1'b0;
         m_h2  = 1'b0;
         m_lvl = 1'b0;
         m_tog = 1'b0;
         m_run = 0;
         m_age = 0;
      end else begin
         s    = m_h2;
         m_h2 = m_h1;
         m_h1 = b;
         if (s != m_lvl) m_run++;
         else m_run = 0;
         if (m_run == D + 1) begin
            m_run = 0;
            m_lvl = !m_lvl;
            if (m_lvl) begin
               m_rise = 1'b1;
               m_tog  = !m_tog;
               m_age  = 0;
            end else begin
               m_fall = 1'b1;
            end
         end else if (m_lvl) begin
            m_age++;
            if (m_age == H - 1) m_long = 1'b1;
         end
      end
   endtask

   task automatic step(input bit r, input bit b);
      reset  = r;
      btn_in = b;
      @(posedge clk);
      model_edge(r, b);
      #1;
      chk("level", int'(level), int'(m_lvl));
      chk("rise", int'(rise), int'(m_rise));
      chk("fall", int'(fall), int'(m_fall));
      chk("toggle", int'(toggle), int'(m_tog));
      chk("long", int'(long_p), int'(m_long));
      if (rise === 1'b1) seg_r++;
      if (fall === 1'b1) seg_f++;
      if (long_p === 1'b1) begin
         seg_l++;
         if (first_l < 0) first_l = seg_idx;
      end
      if ((rise | fall | long_p) === 1'b1 && first_p < 0) first_p = seg_idx;
      seg_idx++;
   endtask

   task automatic seg_start();
      seg_idx = 0;
      seg_r   = 0;
      seg_f   = 0;
      seg_l   = 0;
      first_p = -1;
      first_l = -1;
   endtask

   initial begin
      int rem;
      bit cur;
      reset  = 1'b1;
      btn_in = 1'b1;

      segs[0]  = '{1, 1,  3, 0, 0, 0, 0, 0, -1, -1};
      segs[1]  = '{0, 1, 10, 1, 1, 1, 0, 0,  6, -1};
      segs[2]  = '{0, 0, 10, 0, 1, 0, 1, 0,  6, -1};
      segs[3]  = '{0, 1, 30, 1, 0, 1, 0, 1,  6, 21};
      segs[4]  = '{0, 0,  8, 0, 0, 0, 1, 0,  6, -1};
      segs[5]  = '{0, 1,  4, 0, 0, 0, 0, 0, -1, -1};
      segs[6]  = '{1, 1,  1, 0, 0, 0, 0, 0, -1, -1};
      segs[7]  = '{0, 0,  8, 0, 0, 0, 0, 0, -1, -1};
      segs[8]  = '{0, 1, 12, 1, 1, 1, 0, 0,  6, -1};
      segs[9]  = '{1, 1,  2, 0, 0, 0, 0, 0, -1, -1};
      segs[10] = '{0, 0,  8, 0, 0, 0, 0, 0, -1, -1};

      for (int i = 0; i < 11; i++) begin
         seg_start();
         for (int k = 0; k < segs[i].n; k++) step(segs[i].rst, segs[i].btn);
         chk($sformatf("seg%0d_level", i), int'(level), int'(segs[i].lvl));
         chk($sformatf("seg%0d_toggle", i), int'(toggle), int'(segs[i].tog));
         chk($sformatf("seg%0d_rises", i), seg_r, segs[i].rises);
         chk($sformatf("seg%0d_falls", i), seg_f, segs[i].falls);
         chk($sformatf("seg%0d_longs", i), seg_l, segs[i].longs);
         chk($sformatf("seg%0d_t_first", i), first_p, segs[i].t_first);
         chk($sformatf("seg%0d_t_long", i), first_l, segs[i].t_long);
      end

      // bounce 1,0,1,1,0 then steady: rise 4 stable cycles + 2 after idx 5
      seg_start();
      step(0, 1); step(0, 0); step(0, 1); step(0, 1); step(0, 0);
      for (int k = 0; k < 12; k++) step(0, 1);
      chk("bounce_rises", seg_r, 1);
      chk("bounce_t_rise", first_p, 11);
      chk("bounce_toggle", int'(toggle), 1);
      seg_start();
      for (int k = 0; k < 10; k++) step(0, 0);
      chk("bounce_release_fall", first_p, 6);

      // randomized runs, including glitches, long holds and rare resets
      rem = 0;
      cur = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (rem == 0) begin
            cur = 1'($urandom_range(0, 1));
            rem = ($urandom_range(0, 3) == 0) ? int'($urandom_range(18, 40))
                                             : int'($urandom_range(1, 8));
         end
         rem--;
         step($urandom_range(0, 249) == 0, cur);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
